// File: rtl/jt51_pg_pkg.sv
// Shared constants and helpers for the jt51 phase generator.
// The phase-increment ROM contents are built here once, so every user
// of the table sees identical values.
package jt51_pg_pkg;

    localparam int PW        = 20;   // phase accumulator width
    localparam int KCW       = 13;   // extended key code width
    localparam int ROMW      = 12;   // ROM word width
    localparam int SLOTS     = 32;   // operator slots per sample
    localparam int ROM_DEPTH = 768;  // 12 notes x 64 fractional steps

    // (2^(1/768) - 1) scaled by 2^60: ratio between adjacent ROM entries.
    localparam logic [63:0] R_FRAC = 64'd1041022170371633;

    // Collapse the 16-code note field onto 0..11 (codes 3, 7, 11, 15 unused).
    function automatic logic [3:0] note_idx(input logic [3:0] note);
        return note - {2'b00, note[3:2]};
    endfunction

    // rom[i] = round(2048 * 2^(i/768)), built by repeated multiplication
    // with 60 fractional bits so rounding errors stay far below 1/2 LSB.
    function automatic logic [ROM_DEPTH*ROMW-1:0] gen_rom_table();
        logic [127:0]                v;
        logic [127:0]                r;
        logic [127:0]                prod;
        logic [127:0]                scaled;
        logic [ROM_DEPTH*ROMW-1:0]   t;
        t = '0;
        v = 128'd1 << 60;
        r = v + {64'd0, R_FRAC};
        for (int i = 0; i < ROM_DEPTH; i++) begin
            scaled = (v << 11) + (128'd1 << 59);
            t[i*ROMW +: ROMW] = scaled[71:60];
            prod = v * r;
            v = prod >> 60;
        end
        return t;
    endfunction

    localparam logic [ROM_DEPTH*ROMW-1:0] ROM_BITS = gen_rom_table();

    // Table lookup; indices beyond the last entry read the last entry.
    function automatic logic [ROMW-1:0] rom_value(input logic [9:0] idx);
        logic [9:0] a;
        a = (idx > 10'd767) ? 10'd767 : idx;
        return ROM_BITS[a*ROMW +: ROMW];
    endfunction

endpackage

// File: rtl/jt51_pg_if.sv
// Per-slot operator bus into the phase generator and its phase output.
// There is no valid/ready handshake: the producer presents exactly one
// slot per cen cycle in fixed cyclic order and every cen edge samples it.
interface jt51_pg_if;
    import jt51_pg_pkg::*;

    logic [KCW-1:0] kcex;
    logic [2:0]     dt1;
    logic [3:0]     mul;
    logic           pg_rst;
    logic           zero;
    logic [9:0]     pg_phase;
    logic           zero_out;

    modport master (
        output kcex, dt1, mul, pg_rst, zero,
        input  pg_phase, zero_out
    );

    modport slave (
        input  kcex, dt1, mul, pg_rst, zero,
        output pg_phase, zero_out
    );

endinterface

// File: rtl/jt51_phinc_rom.sv
// 768 x 12 synchronous phase-increment ROM; its output register is the
// first pipeline stage of the phase generator.
module jt51_phinc_rom
    import jt51_pg_pkg::*;
(
    input  logic            rst_n,
    input  logic            clk,
    input  logic            cen,
    input  logic [9:0]      addr,
    output logic [ROMW-1:0] data
);

    // Registered table read, advancing only on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (cen) begin
            data <= rom_value(addr);
        end
    end

endmodule

// File: rtl/jt51_pg.sv
// Phase generator: key code -> phase increment (ROM, octave, detune,
// multiplier), then accumulation into a 32-slot circular phase store.
// S1 = ROM read, S2 = octave shift + detune, S3 = multiply + accumulate.
module jt51_pg
    import jt51_pg_pkg::*;
#(
    parameter int SLOTS = jt51_pg_pkg::SLOTS,
    parameter int PW    = jt51_pg_pkg::PW
)
(
    input  logic     rst_n,
    input  logic     clk,
    input  logic     cen,
    jt51_pg_if.slave pg
);

    localparam int IW = (PW > 22) ? PW : 22;

    // S1 registers
    logic [ROMW-1:0] base1;
    logic [2:0]      oct1;
    logic [4:0]      kc51;
    logic [2:0]      dt1_1;
    logic [3:0]      mul1;
    logic            rst1;
    logic            zero1;

    // S2 registers
    logic [17:0]     ph2;
    logic [3:0]      mul2;
    logic            rst2;
    logic            zero2;

    // Phase ring: entry SLOTS-1 is the head, holding the phase of the slot
    // now in S3 as written one full rotation ago.
    logic [PW-1:0]   ring [SLOTS];

    logic [9:0]      rom_addr;
    logic [18:0]     shifted;
    logic [17:0]     ph_base;
    logic [6:0]      dt_prod;
    logic [5:0]      dtoff;
    logic [17:0]     ph_next;
    logic [IW-1:0]   inc_full;
    logic [PW-1:0]   inc;
    logic [PW-1:0]   phase_new;

    assign rom_addr = {note_idx(pg.kcex[9:6]), pg.kcex[5:0]};

    jt51_phinc_rom u_rom (
        .rst_n (rst_n),
        .clk   (clk),
        .cen   (cen),
        .addr  (rom_addr),
        .data  (base1)
    );

    // S1: side data travels with the ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oct1  <= '0;
            kc51  <= '0;
            dt1_1 <= '0;
            mul1  <= '0;
            rst1  <= 1'b0;
            zero1 <= 1'b0;
        end else if (cen) begin
            oct1  <= pg.kcex[12:10];
            kc51  <= pg.kcex[12:8];
            dt1_1 <= pg.dt1;
            mul1  <= pg.mul;
            rst1  <= pg.pg_rst;
            zero1 <= pg.zero;
        end
    end

    // S2 combinational: octave shift then signed detune, clamped at zero.
    always_comb begin
        shifted = {7'd0, base1} << oct1;
        ph_base = shifted[18:1];
        dt_prod = {2'b00, kc51} * {5'd0, dt1_1[1:0]};
        dtoff   = dt_prod[6:1];
        ph_next = ph_base + {12'd0, dtoff};
        if (dt1_1[2]) begin
            ph_next = (ph_base >= {12'd0, dtoff}) ? (ph_base - {12'd0, dtoff}) : 18'd0;
        end
    end

    // S2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph2   <= '0;
            mul2  <= '0;
            rst2  <= 1'b0;
            zero2 <= 1'b0;
        end else if (cen) begin
            ph2   <= ph_next;
            mul2  <= mul1;
            rst2  <= rst1;
            zero2 <= zero1;
        end
    end

    // S3 combinational: MUL=0 means x1/2; sum wraps modulo 2^PW.
    always_comb begin
        inc_full  = (mul2 == 4'd0) ? IW'(ph2[17:1]) : (IW'(ph2) * IW'(mul2));
        inc       = inc_full[PW-1:0];
        phase_new = rst2 ? '0 : (ring[SLOTS-1] + inc);
    end

    // S3: rotate the ring, inserting the new phase, and publish it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                ring[i] <= '0;
            end
            pg.pg_phase <= '0;
            pg.zero_out <= 1'b0;
        end else if (cen) begin
            ring[0] <= phase_new;
            for (int i = 1; i < SLOTS; i++) begin
                ring[i] <= ring[i-1];
            end
            pg.pg_phase <= phase_new[PW-1:PW-10];
            pg.zero_out <= zero2;
        end
    end

endmodule

// File: tb/tb_jt51_pg.sv
// Bench for jt51_pg: a per-slot reference model pushes the expected
// {zero_out, pg_phase} of every driven slot; each test pops and compares
// once the three-stage pipeline delivers it.
module tb_jt51_pg;
    import jt51_pg_pkg::*;

    // Queue item: {test[3:0], frame[7:0], slot[4:0], zero, phase[9:0]}
    localparam int W = 28;

    logic clk = 1'b0;
    logic rst_n;
    logic cen;

    jt51_pg_if pg();

    jt51_pg #(.SLOTS(32), .PW(20)) dut (
        .rst_n (rst_n),
        .clk   (clk),
        .cen   (cen),
        .pg    (pg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           fails  = 0;

    logic [12:0]  cfg_kcex [32];
    logic [2:0]   cfg_dt1  [32];
    logic [3:0]   cfg_mul  [32];
    logic         cfg_rst  [32];
    logic [19:0]  phase_m  [32];
    int           cur;
    int           test_id;
    int           frame;

    localparam logic [12:0] KC_BASIC = 13'h1000;           // {4,0,0}
    localparam logic [12:0] KC_TOP   = {3'd7, 4'd14, 6'd63};

    // Reference increment, written in plain integer arithmetic.
    function automatic int unsigned model_inc(input logic [12:0] kc, input logic [2:0] d,
                                              input logic [3:0] m);
        int unsigned oct_v, note_v, frac_v, kc5_v, mag_v, mul_v;
        int unsigned idx, base, ph, off, inc;
        oct_v  = 32'(kc[12:10]);
        note_v = 32'(kc[9:6]);
        frac_v = 32'(kc[5:0]);
        kc5_v  = 32'(kc[12:8]);
        mag_v  = 32'(d[1:0]);
        mul_v  = 32'(m);
        idx    = (note_v - note_v / 4) * 64 + frac_v;
        base   = 32'(rom_value(idx[9:0]));
        ph     = (base * (32'd1 << oct_v)) / 2;
        off    = (kc5_v * mag_v) / 2;
        if (d[2]) ph = (ph >= off) ? ph - off : 0;
        else      ph = ph + off;
        inc = (mul_v == 0) ? ph / 2 : ph * mul_v;
        return inc % 32'h100000;
    endfunction

    // driver: present the current slot and queue its expected output
    task automatic drive_slot();
        logic [19:0] nxt;
        pg.kcex   = cfg_kcex[cur];
        pg.dt1    = cfg_dt1[cur];
        pg.mul    = cfg_mul[cur];
        pg.pg_rst = cfg_rst[cur];
        pg.zero   = (cur == 0);
        nxt = cfg_rst[cur] ? 20'd0
                           : 20'(32'(phase_m[cur]) + model_inc(cfg_kcex[cur], cfg_dt1[cur], cfg_mul[cur]));
        phase_m[cur] = nxt;
        exp_q.push_back({4'(test_id), 8'(frame), 5'(cur), (cur == 0), nxt[19:10]});
        cur = (cur + 1) % 32;
    endtask

    task automatic step(output logic vld, output logic [W-1:0] got);
        drive_slot();
        @(posedge clk);
        #1;
        vld = 1'b0;
        got = '0;
        if (exp_q.size() > 2) begin
            vld = 1'b1;
            got = exp_q.pop_front();
        end
    endtask

    task automatic set_basic();
        for (int s = 0; s < 32; s++) begin
            cfg_kcex[s] = KC_BASIC;
            cfg_dt1[s]  = 3'd0;
            cfg_mul[s]  = 4'd1;
            cfg_rst[s]  = 1'b0;
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int s = 0; s < 32; s++) phase_m[s] = '0;
        cur = 0;
    endtask

    task automatic test_reset();
        logic         vld;
        logic [W-1:0] got;
        logic [10:0]  obs;
        int           pulses;
        test_id = 0;
        frame   = 0;
        set_basic();
        clear_model();
        rst_n = 1'b0;
        cen   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        obs = {pg.zero_out, pg.pg_phase};
        checks++;
        if (obs !== 11'd0) begin
            fails++;
            $display("FAIL reset_hold: got %h expected %h", obs, 11'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(vld, got);
            obs = {pg.zero_out, pg.pg_phase};
            if (vld) begin
                checks++;
                if (obs !== got[10:0]) begin
                    fails++;
                    $display("FAIL reset_pre slot %0d: got %h expected %h", got[15:11], obs, got[10:0]);
                end
            end
        end
        // asynchronous reset in the middle of a frame
        #2 rst_n = 1'b0;
        #1;
        obs = {pg.zero_out, pg.pg_phase};
        checks++;
        if (obs !== 11'd0) begin
            fails++;
            $display("FAIL reset_async: got %h expected %h", obs, 11'd0);
        end
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step(vld, got);
            obs = {pg.zero_out, pg.pg_phase};
            if (vld) begin
                checks++;
                if (obs !== got[10:0]) begin
                    fails++;
                    $display("FAIL reset_ring slot %0d: got %h expected %h", got[15:11], obs, got[10:0]);
                end
            end
        end
        // key-on on every slot: all phases forced to zero
        test_id = 1;
        for (int s = 0; s < 32; s++) cfg_rst[s] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 34; i++) begin
            step(vld, got);
            obs = {pg.zero_out, pg.pg_phase};
            if (i < 32 && obs[10]) pulses++;
            if (vld) begin
                checks++;
                if (obs !== got[10:0]) begin
                    fails++;
                    $display("FAIL reset_zero slot %0d: got %h expected %h", got[15:11], obs, got[10:0]);
                end
                if (got[27:24] == 4'd1) begin
                    checks++;
                    if (obs[9:0] !== 10'd0) begin
                        fails++;
                        $display("FAIL reset_phase0 slot %0d: got %0d expected 0", got[15:11], obs[9:0]);
                    end
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL reset_zero_pulse: got %0d pulses in 32 cen expected 1", pulses);
        end
        set_basic();
    endtask

    task automatic test_accumulate();
        logic         vld;
        logic [W-1:0] got;
        logic [10:0]  obs;
        int           ex;
        test_id = 2;
        for (int f = 0; f < 65; f++) begin
            frame = f;
            for (int s = 0; s < 32; s++) begin
                step(vld, got);
                obs = {pg.zero_out, pg.pg_phase};
                if (!vld) continue;
                checks++;
                if (obs !== got[10:0]) begin
                    fails++;
                    $display("FAIL accum slot %0d: got %h expected %h", got[15:11], obs, got[10:0]);
                end
                if (got[27:24] == 4'd2 && got[15:11] == 5'd7) begin
                    ex = (16 * (int'(got[23:16]) + 1)) % 1024;
                    checks++;
                    if (obs[9:0] !== 10'(ex)) begin
                        fails++;
                        $display("FAIL accum_slot7 visit %0d: got %0d expected %0d", got[23:16] + 1, obs[9:0], ex);
                    end
                    if (got[23:16] == 8'd63) begin
                        checks++;
                        if (obs[9:0] !== 10'd0) begin
                            fails++;
                            $display("FAIL accum_wrap: got %0d expected 0", obs[9:0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_mul();
        logic         vld;
        logic [W-1:0] got;
        logic [10:0]  obs;
        logic [9:0]   prev3;
        logic         have3;
        longint       ex;
        test_id = 3;
        have3 = 1'b0;
        prev3 = '0;
        cfg_mul[3]  = 4'd0;
        cfg_kcex[9] = KC_TOP;
        cfg_mul[9]  = 4'd15;
        for (int f = 0; f < 6; f++) begin
            frame = f;
            cfg_rst[9] = (f == 0);
            for (int s = 0; s < 32; s++) begin
                step(vld, got);
                obs = {pg.zero_out, pg.pg_phase};
                if (!vld) continue;
                checks++;
                if (obs !== got[10:0]) begin
                    fails++;
                    $display("FAIL mul slot %0d: got %h expected %h", got[15:11], obs, got[10:0]);
                end
                if (got[27:24] == 4'd3 && got[15:11] == 5'd3) begin
                    if (have3) begin
                        checks++;
                        if (10'(obs[9:0] - prev3) !== 10'd8) begin
                            fails++;
                            $display("FAIL mul0_step: got step %0d expected 8", 10'(obs[9:0] - prev3));
                        end
                    end
                    prev3 = obs[9:0];
                    have3 = 1'b1;
                end
                if (got[27:24] == 4'd3 && got[15:11] == 5'd9) begin
                    ex = ((longint'(got[23:16]) * 782592) % 1048576) >> 10;
                    checks++;
                    if (obs[9:0] !== 10'(ex)) begin
                        fails++;
                        $display("FAIL mul15_top frame %0d: got %0d expected %0d", got[23:16], obs[9:0], ex);
                    end
                end
            end
        end
        set_basic();
    endtask

    task automatic test_dt1();
        logic         vld;
        logic [W-1:0] got;
        logic [10:0]  obs;
        test_id = 4;
        cfg_dt1[11] = 3'b010;
        cfg_dt1[12] = 3'b110;
        for (int f = 0; f < 65; f++) begin
            frame = f;
            cfg_rst[11] = (f == 0);
            cfg_rst[12] = (f == 0);
            for (int s = 0; s < 32; s++) begin
                step(vld, got);
                obs = {pg.zero_out, pg.pg_phase};
                if (!vld) continue;
                checks++;
                if (obs !== got[10:0]) begin
                    fails++;
                    $display("FAIL dt1 slot %0d: got %h expected %h", got[15:11], obs, got[10:0]);
                end
                if (got[27:24] == 4'd4 && (got[23:16] == 8'd1 || got[23:16] == 8'd64)) begin
                    if (got[15:11] == 5'd11) begin
                        checks++;
                        if (obs[9:0] !== ((got[23:16] == 8'd1) ? 10'd16 : 10'd1)) begin
                            fails++;
                            $display("FAIL dt1_plus frame %0d: got %0d expected %0d", got[23:16], obs[9:0],
                                     (got[23:16] == 8'd1) ? 16 : 1);
                        end
                    end
                    if (got[15:11] == 5'd12) begin
                        checks++;
                        if (obs[9:0] !== ((got[23:16] == 8'd1) ? 10'd15 : 10'd1023)) begin
                            fails++;
                            $display("FAIL dt1_minus frame %0d: got %0d expected %0d", got[23:16], obs[9:0],
                                     (got[23:16] == 8'd1) ? 15 : 1023);
                        end
                    end
                end
            end
        end
        set_basic();
    endtask

    task automatic test_key_on();
        logic         vld;
        logic [W-1:0] got;
        logic [10:0]  obs;
        test_id = 5;
        for (int f = 0; f < 14; f++) begin
            frame = f;
            cfg_rst[5] = (f == 10);
            for (int s = 0; s < 32; s++) begin
                step(vld, got);
                obs = {pg.zero_out, pg.pg_phase};
                if (!vld) continue;
                checks++;
                if (obs !== got[10:0]) begin
                    fails++;
                    $display("FAIL key_on slot %0d: got %h expected %h", got[15:11], obs, got[10:0]);
                end
                if (got[27:24] == 4'd5 && got[15:11] == 5'd5 && (got[23:16] == 8'd10 || got[23:16] == 8'd11)) begin
                    checks++;
                    if (obs[9:0] !== ((got[23:16] == 8'd10) ? 10'd0 : 10'd16)) begin
                        fails++;
                        $display("FAIL key_on_slot5 frame %0d: got %0d expected %0d", got[23:16], obs[9:0],
                                 (got[23:16] == 8'd10) ? 0 : 16);
                    end
                end
            end
        end
        set_basic();
    endtask

    task automatic test_cen_gating();
        logic         vld;
        logic [W-1:0] got;
        logic [10:0]  obs;
        logic [10:0]  hold;
        test_id = 6;
        frame   = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 5) begin
                hold = {pg.zero_out, pg.pg_phase};
                cen  = 1'b0;
                for (int g = 0; g < 7; g++) begin
                    pg.kcex   = 13'($urandom_range(0, 8191));
                    pg.dt1    = 3'($urandom_range(0, 7));
                    pg.mul    = 4'($urandom_range(0, 15));
                    pg.pg_rst = 1'($urandom_range(0, 1));
                    pg.zero   = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                    obs = {pg.zero_out, pg.pg_phase};
                    checks++;
                    if (obs !== hold) begin
                        fails++;
                        $display("FAIL cen_hold cycle %0d: got %h expected %h", g, obs, hold);
                    end
                end
                cen = 1'b1;
            end
            step(vld, got);
            obs = {pg.zero_out, pg.pg_phase};
            if (vld) begin
                checks++;
                if (obs !== got[10:0]) begin
                    fails++;
                    $display("FAIL cen_resume slot %0d: got %h expected %h", got[15:11], obs, got[10:0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic         vld;
        logic [W-1:0] got;
        logic [10:0]  obs;
        logic [3:0]   notes [12];
        notes = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14};
        test_id = 7;
        for (int f = 0; f < 4; f++) begin
            frame = f;
            for (int s = 0; s < 32; s++) begin
                cfg_kcex[s] = {3'($urandom_range(0, 7)), notes[$urandom_range(0, 11)], 6'($urandom_range(0, 63))};
                cfg_dt1[s]  = 3'($urandom_range(0, 7));
                cfg_mul[s]  = 4'($urandom_range(0, 15));
                cfg_rst[s]  = ($urandom_range(0, 7) == 0);
            end
            for (int s = 0; s < 32; s++) begin
                step(vld, got);
                obs = {pg.zero_out, pg.pg_phase};
                if (vld) begin
                    checks++;
                    if (obs !== got[10:0]) begin
                        fails++;
                        $display("FAIL random slot %0d: got %h expected %h", got[15:11], obs, got[10:0]);
                    end
                end
            end
        end
        // drain the two slots still in flight
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            obs = {pg.zero_out, pg.pg_phase};
            got = exp_q.pop_front();
            checks++;
            if (obs !== got[10:0]) begin
                fails++;
                $display("FAIL drain slot %0d: got %h expected %h", got[15:11], obs, got[10:0]);
            end
        end
    endtask

    initial begin
        pg.kcex   = '0;
        pg.dt1    = '0;
        pg.mul    = '0;
        pg.pg_rst = 1'b0;
        pg.zero   = 1'b0;
        checks++;
        if (rom_value(10'd0) !== 12'd2048 || rom_value(10'd767) !== 12'd4092) begin
            fails++;
            $display("FAIL rom_ends: got %0d/%0d expected 2048/4092", rom_value(10'd0), rom_value(10'd767));
        end
        test_reset();
        test_accumulate();
        test_mul();
        test_dt1();
        test_key_on();
        test_cen_gating();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
